// File: rtl/pwm_regs_mc.sv
// Register file for a multi-channel PWM peripheral: shared counter configuration,
// NUM_CH compare/function channels, double-buffered active set, reset pulse and IRQ.
module pwm_regs_mc #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int RST_PULSE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      read,
  input  logic                      write,
  input  logic [5:0]                addr,
  input  logic [7:0]                data_write,
  output logic [7:0]                data_read,
  input  logic [CNT_W-1:0]          counter_val,
  input  logic                      period_end,
  output logic [CNT_W-1:0]          period,
  output logic                      en,
  output logic                      upnotdown,
  output logic [7:0]                prescale,
  output logic                      count_reset,
  output logic [NUM_CH-1:0]         pwm_en,
  output logic [2*NUM_CH-1:0]       functions,
  output logic [CNT_W*NUM_CH-1:0]   compare1,
  output logic [CNT_W*NUM_CH-1:0]   compare2,
  output logic                      irq
);

  localparam int         HI_W      = CNT_W - 8;
  localparam logic [3:0] PULSE_LEN = 4'(RST_PULSE);

  localparam logic [5:0] A_PER_LO = 6'h00;
  localparam logic [5:0] A_PER_HI = 6'h01;
  localparam logic [5:0] A_CTRL   = 6'h02;
  localparam logic [5:0] A_PRESC  = 6'h03;
  localparam logic [5:0] A_TRIG   = 6'h04;
  localparam logic [5:0] A_STATUS = 6'h07;
  localparam logic [5:0] A_IRQ_EN = 6'h08;
  localparam logic [5:0] A_COMMIT = 6'h09;

  // Bus protocol: read and write are single-cycle strobes sampled on clk. A read
  // returns its data on data_read in the following cycle; data_read is 0 otherwise.
  // A write in the same cycle as a read of the same address does not affect that read.

  logic [CNT_W-1:0] period_stg;
  logic             shadow_en;
  logic             pending;
  logic [1:0]       status;
  logic [1:0]       irq_en;
  logic [3:0]       pulse_cnt;

  logic [CNT_W-1:0] cmp1_stg [NUM_CH];
  logic [CNT_W-1:0] cmp2_stg [NUM_CH];
  logic [1:0]       func_stg [NUM_CH];
  logic [CNT_W-1:0] cmp1_act [NUM_CH];
  logic [CNT_W-1:0] cmp2_act [NUM_CH];
  logic [1:0]       func_act [NUM_CH];

  logic       glb_sel;
  logic       ch_sel;
  logic [2:0] ch_idx;
  logic       wr_ctrl;
  logic       wr_commit;
  logic       xfer;
  logic       follow;
  logic [1:0] status_clr;
  logic [1:0] status_set;
  logic [7:0] rd_mux;

  function automatic logic [7:0] hi_byte(input logic [CNT_W-1:0] v);
    logic [15:0] w;
    w = 16'(v);
    return w[15:8];
  endfunction

  assign glb_sel = (addr[5:4] == 2'b00);
  assign ch_idx  = addr[5:3] - 3'd2;
  assign ch_sel  = !glb_sel && (int'(ch_idx) < NUM_CH);

  assign wr_ctrl   = write && (addr == A_CTRL);
  assign wr_commit = write && (addr == A_COMMIT);

  // The active set loads from staging every cycle when unshadowed, else only on a
  // committed period boundary; staging writes on that edge are not yet visible.
  assign xfer   = shadow_en && pending && period_end;
  assign follow = !shadow_en || xfer;

  assign status_clr  = (write && (addr == A_STATUS)) ? data_write[1:0] : 2'b00;
  assign status_set  = {xfer, period_end};
  assign count_reset = (pulse_cnt != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_stg <= '0;
      period     <= '0;
      en         <= 1'b0;
      upnotdown  <= 1'b1;
      shadow_en  <= 1'b0;
      prescale   <= '0;
      pending    <= 1'b0;
      status     <= '0;
      irq_en     <= '0;
      irq        <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      if (write && addr == A_PER_LO) period_stg[7:0] <= data_write;
      if (write && addr == A_PER_HI) period_stg[CNT_W-1:8] <= data_write[HI_W-1:0];
      if (wr_ctrl) {shadow_en, upnotdown, en} <= data_write[2:0];
      if (write && addr == A_PRESC) prescale <= data_write;
      if (write && addr == A_IRQ_EN) irq_en <= data_write[1:0];
      if (follow) period <= period_stg;

      if (write && addr == A_TRIG) pulse_cnt <= PULSE_LEN;
      else if (pulse_cnt != 4'd0)  pulse_cnt <= pulse_cnt - 4'd1;

      if (!shadow_en || (wr_ctrl && !data_write[2])) pending <= 1'b0;
      else if (wr_commit)                            pending <= 1'b1;
      else if (xfer)                                 pending <= 1'b0;

      status <= (status & ~status_clr) | status_set;
      irq    <= |(status & irq_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_en <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        cmp1_stg[k] <= '0;
        cmp2_stg[k] <= '0;
        func_stg[k] <= '0;
        cmp1_act[k] <= '0;
        cmp2_act[k] <= '0;
        func_act[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (write && ch_sel && ch_idx == 3'(k)) begin
          case (addr[2:0])
            3'd0: cmp1_stg[k][7:0]       <= data_write;
            3'd1: cmp1_stg[k][CNT_W-1:8] <= data_write[HI_W-1:0];
            3'd2: cmp2_stg[k][7:0]       <= data_write;
            3'd3: cmp2_stg[k][CNT_W-1:8] <= data_write[HI_W-1:0];
            3'd4: begin
              pwm_en[k]   <= data_write[0];
              func_stg[k] <= data_write[2:1];
            end
            default: ;
          endcase
        end
        if (follow) begin
          cmp1_act[k] <= cmp1_stg[k];
          cmp2_act[k] <= cmp2_stg[k];
          func_act[k] <= func_stg[k];
        end
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (glb_sel) begin
      case (addr[3:0])
        4'h0: rd_mux = period_stg[7:0];
        4'h1: rd_mux = hi_byte(period_stg);
        4'h2: rd_mux = {5'b0, shadow_en, upnotdown, en};
        4'h3: rd_mux = prescale;
        4'h5: rd_mux = counter_val[7:0];
        4'h6: rd_mux = hi_byte(counter_val);
        4'h7: rd_mux = {6'b0, status};
        4'h8: rd_mux = {6'b0, irq_en};
        default: rd_mux = 8'h00;
      endcase
    end else if (ch_sel) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_idx == 3'(k)) begin
          case (addr[2:0])
            3'd0: rd_mux = cmp1_stg[k][7:0];
            3'd1: rd_mux = hi_byte(cmp1_stg[k]);
            3'd2: rd_mux = cmp2_stg[k][7:0];
            3'd3: rd_mux = hi_byte(cmp2_stg[k]);
            3'd4: rd_mux = {5'b0, func_stg[k], pwm_en[k]};
            default: rd_mux = 8'h00;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data_read <= '0;
    else if (read) data_read <= rd_mux;
    else           data_read <= '0;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign compare1[CNT_W*k +: CNT_W] = cmp1_act[k];
    assign compare2[CNT_W*k +: CNT_W] = cmp2_act[k];
    assign functions[2*k +: 2]        = func_act[k];
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Bench for pwm_regs_mc: register readback table plus hand-written sequences for
// shadow transfer, reset pulse, interrupt, unmapped access and narrow-counter cases.
module tb_pwm_regs_mc;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic clk, rst_n, read, write, write12, period_end;
  logic [5:0]  addr;
  logic [7:0]  data_write;
  logic [15:0] counter_val;

  logic [7:0]               data_read;
  logic [CNT_W-1:0]         period;
  logic                     en, upnotdown, count_reset, irq;
  logic [7:0]               prescale;
  logic [NUM_CH-1:0]        pwm_en;
  logic [2*NUM_CH-1:0]      functions;
  logic [CNT_W*NUM_CH-1:0]  compare1, compare2;

  logic [7:0]  data_read12, prescale12;
  logic [11:0] period12;
  logic        en12, upnotdown12, count_reset12, irq12;
  logic [3:0]  pwm_en12;
  logic [7:0]  functions12;
  logic [47:0] compare1_12, compare2_12;

  pwm_regs_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_PULSE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .counter_val(counter_val),
    .period_end(period_end), .period(period), .en(en), .upnotdown(upnotdown),
    .prescale(prescale), .count_reset(count_reset), .pwm_en(pwm_en),
    .functions(functions), .compare1(compare1), .compare2(compare2), .irq(irq)
  );

  pwm_regs_mc #(.NUM_CH(4), .CNT_W(12), .RST_PULSE(2)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write12), .addr(addr),
    .data_write(data_write), .data_read(data_read12), .counter_val(counter_val[11:0]),
    .period_end(1'b0), .period(period12), .en(en12), .upnotdown(upnotdown12),
    .prescale(prescale12), .count_reset(count_reset12), .pwm_en(pwm_en12),
    .functions(functions12), .compare1(compare1_12), .compare2(compare2_12), .irq(irq12)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  bit         sel_q[$];
  string      name_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    write = 1'b1;
    addr = a;
    data_write = d;
    tick();
    write = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [7:0] e, input bit s, input string n);
    exp_q.push_back(e);
    sel_q.push_back(s);
    name_q.push_back(n);
    read = 1'b1;
    addr = a;
    tick();
    read = 1'b0;
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  // scoreboard: a read accepted at an edge is checked just after the following edge
  always begin : monitor
    logic       rd_seen;
    logic [7:0] e;
    bit         s;
    string      n;
    @(posedge clk);
    rd_seen = read;
    #1;
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", 256'(data_read), 256'(0));
      end else begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        n = name_q.pop_front();
        chk(n, 256'(s ? data_read12 : data_read), 256'(e));
      end
    end
  end

  typedef struct {
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [7:0]   bits;
    logic [255:0] snap;

    tbl[0]  = '{6'h03, 8'hA5, 8'hA5};
    tbl[1]  = '{6'h08, 8'hFF, 8'h03};
    tbl[2]  = '{6'h04, 8'hFF, 8'h00};
    tbl[3]  = '{6'h05, 8'h77, 8'hEF};
    tbl[4]  = '{6'h06, 8'h77, 8'hBE};
    tbl[5]  = '{6'h09, 8'hFF, 8'h00};
    tbl[6]  = '{6'h28, 8'h5A, 8'h5A};
    tbl[7]  = '{6'h29, 8'hC3, 8'hC3};
    tbl[8]  = '{6'h2B, 8'h11, 8'h11};
    tbl[9]  = '{6'h2C, 8'hFD, 8'h05};
    tbl[10] = '{6'h0A, 8'h55, 8'h00};
    tbl[11] = '{6'h2D, 8'h66, 8'h00};
    tbl[12] = '{6'h38, 8'h12, 8'h00};
    tbl[13] = '{6'h01, 8'hFF, 8'hFF};
    tbl[14] = '{6'h0F, 8'h55, 8'h00};

    rst_n = 1'b1; read = 1'b0; write = 1'b0; write12 = 1'b0; period_end = 1'b0;
    addr = '0; data_write = '0; counter_val = 16'hBEEF;

    // asynchronous reset, asserted before the first clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("rst_period", 256'(period), 256'(0));
    chk("rst_en", 256'(en), 256'(0));
    chk("rst_upnotdown", 256'(upnotdown), 256'(1));
    chk("rst_prescale", 256'(prescale), 256'(0));
    chk("rst_count_reset", 256'(count_reset), 256'(0));
    chk("rst_pwm_en", 256'(pwm_en), 256'(0));
    chk("rst_functions", 256'(functions), 256'(0));
    chk("rst_compare1", 256'(compare1), 256'(0));
    chk("rst_compare2", 256'(compare2), 256'(0));
    chk("rst_irq", 256'(irq), 256'(0));
    chk("rst_data_read", 256'(data_read), 256'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    do_read(6'h02, 8'h02, 1'b0, "rst_ctrl_read");

    // immediate mode period update
    do_write(6'h00, 8'h34);
    do_write(6'h01, 8'h12);
    tick();
    chk("imm_period", 256'(period), 256'(16'h1234));
    do_read(6'h01, 8'h12, 1'b0, "imm_period_hi_read");
    tick();
    chk("read_idle_zero", 256'(data_read), 256'(0));

    for (int i = 0; i < 15; i++) begin
      do_write(tbl[i].addr, tbl[i].wdata);
      do_read(tbl[i].addr, tbl[i].exp, 1'b0, $sformatf("tbl_%0d_addr_%0h", i, tbl[i].addr));
    end
    tick();
    chk("tbl_prescale", 256'(prescale), 256'(8'hA5));
    chk("tbl_pwm_en", 256'(pwm_en), 256'(4'b1000));
    chk("tbl_functions", 256'(functions), 256'(8'b1000_0000));
    chk("tbl_compare1_ch3", 256'(compare1[63:48]), 256'(16'hC35A));
    chk("tbl_compare2_ch3", 256'(compare2[63:48]), 256'(16'h1100));
    chk("tbl_period", 256'(period), 256'(16'hFF34));

    // read and write of the same address in one cycle returns the old value
    exp_q.push_back(8'hA5); sel_q.push_back(1'b0); name_q.push_back("rw_same_cycle");
    read = 1'b1; write = 1'b1; addr = 6'h03; data_write = 8'h3C;
    tick();
    read = 1'b0; write = 1'b0;
    do_read(6'h03, 8'h3C, 1'b0, "rw_after_write");
    chk("rw_prescale", 256'(prescale), 256'(8'h3C));

    // shadow mode: transfer on the first period_end after commit
    do_write(6'h02, 8'h04);
    chk("ctrl_upnotdown", 256'(upnotdown), 256'(0));
    do_write(6'h18, 8'hCD);
    do_write(6'h19, 8'hAB);
    do_write(6'h09, 8'h01);
    tick(); tick();
    chk("shadow_hold", 256'(compare1[31:16]), 256'(16'h0000));
    do_read(6'h18, 8'hCD, 1'b0, "shadow_staging_read");
    pulse_pe();
    chk("shadow_xfer", 256'(compare1[31:16]), 256'(16'hABCD));
    do_read(6'h07, 8'h03, 1'b0, "status_wrap_upd");
    chk("irq_after_upd", 256'(irq), 256'(1));
    do_write(6'h07, 8'h03);
    do_write(6'h08, 8'h01);

    // commit coincident with period_end only arms the transfer
    do_write(6'h18, 8'h22);
    period_end = 1'b1;
    do_write(6'h09, 8'h01);
    period_end = 1'b0;
    tick();
    chk("commit_pe_no_xfer", 256'(compare1[31:16]), 256'(16'hABCD));
    pulse_pe();
    chk("commit_pe_second", 256'(compare1[31:16]), 256'(16'hAB22));

    // staging write on the transfer edge stays in staging
    do_write(6'h18, 8'h44);
    do_write(6'h09, 8'h01);
    period_end = 1'b1;
    do_write(6'h19, 8'h99);
    period_end = 1'b0;
    chk("xfer_pre_write", 256'(compare1[31:16]), 256'(16'hAB44));
    do_read(6'h19, 8'h99, 1'b0, "xfer_staging_hi");
    pulse_pe();
    chk("xfer_no_rearm", 256'(compare1[31:16]), 256'(16'hAB44));

    // dropping shadow_en while pending cancels the pending transfer
    do_write(6'h09, 8'h01);
    do_write(6'h02, 8'h00);
    tick();
    chk("unshadow_follow", 256'(compare1[31:16]), 256'(16'h9944));
    do_write(6'h02, 8'h04);
    do_write(6'h18, 8'h55);
    pulse_pe();
    chk("unshadow_pending_cleared", 256'(compare1[31:16]), 256'(16'h9944));

    // interrupt and W1C
    do_write(6'h07, 8'h03);
    tick();
    chk("irq_cleared", 256'(irq), 256'(0));
    pulse_pe();
    chk("irq_not_yet", 256'(irq), 256'(0));
    tick();
    chk("irq_rise", 256'(irq), 256'(1));
    do_write(6'h07, 8'h01);
    tick();
    chk("irq_w1c", 256'(irq), 256'(0));
    period_end = 1'b1;
    do_write(6'h07, 8'h01);
    period_end = 1'b0;
    do_read(6'h07, 8'h01, 1'b0, "w1c_vs_set");
    chk("irq_set_wins", 256'(irq), 256'(1));

    // count_reset pulse: single trigger, then back-to-back retrigger
    bits = '0;
    write = 1'b1; addr = 6'h04; data_write = 8'h00;
    tick();
    bits[0] = count_reset;
    write = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      bits[i] = count_reset;
    end
    chk("pulse_single", 256'(bits), 256'(8'b0000_0011));
    bits = '0;
    write = 1'b1; addr = 6'h04;
    tick();
    bits[0] = count_reset;
    tick();
    bits[1] = count_reset;
    write = 1'b0;
    for (int i = 2; i < 8; i++) begin
      tick();
      bits[i] = count_reset;
    end
    chk("pulse_retrigger", 256'(bits), 256'(8'b0000_0111));

    // unmapped writes leave every output untouched
    snap = 256'({period, en, upnotdown, prescale, count_reset, pwm_en, functions,
                 compare1, compare2, irq});
    do_write(6'h3D, 8'hFF);
    do_write(6'h15, 8'hFF);
    tick(); tick();
    chk("unmapped_outputs", 256'({period, en, upnotdown, prescale, count_reset, pwm_en,
                                 functions, compare1, compare2, irq}), snap);
    do_read(6'h3D, 8'h00, 1'b0, "unmapped_read_3d");
    do_read(6'h15, 8'h00, 1'b0, "unmapped_read_15");

    // CNT_W=12 instance drops upper hi-byte bits
    write12 = 1'b1; addr = 6'h01; data_write = 8'hFF;
    tick();
    write12 = 1'b0;
    do_read(6'h01, 8'h0F, 1'b1, "narrow_hi_read");
    chk("narrow_period", 256'(period12), 256'(12'hF00));

    // reset during a count_reset pulse aborts it immediately
    do_write(6'h04, 8'h00);
    chk("pulse_before_reset", 256'(count_reset), 256'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("midpulse_count_reset", 256'(count_reset), 256'(0));
    chk("midpulse_compare1", 256'(compare1), 256'(0));
    chk("midpulse_upnotdown", 256'(upnotdown), 256'(1));
    chk("midpulse_irq", 256'(irq), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
